// File: rtl/cvxif_mac_pipe_coprocessor.sv
// cvxif_mac_pipe_coprocessor: CV-X-IF lane-wise MAC dot-product unit.
// Pipelined datapath, ID-indexed in-flight table, in-order result return.
module cvxif_mac_pipe_coprocessor #(
  parameter int XLEN       = 32,
  parameter int ELEM_WIDTH = 8,
  parameter int ID_WIDTH   = 3,
  parameter int LATENCY    = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  output logic                issue_ready_o,
  input  logic [ID_WIDTH-1:0] issue_id_i,
  input  logic [4:0]          issue_rd_i,
  input  logic [XLEN-1:0]     issue_rs1_i,
  input  logic [XLEN-1:0]     issue_rs2_i,
  input  logic                issue_signed_i,
  input  logic                issue_acc_i,
  input  logic                commit_valid_i,
  input  logic [ID_WIDTH-1:0] commit_id_i,
  input  logic                commit_kill_i,
  output logic                result_valid_o,
  input  logic                result_ready_i,
  output logic [ID_WIDTH-1:0] result_id_o,
  output logic [4:0]          result_rd_o,
  output logic [XLEN-1:0]     result_data_o,
  output logic                result_we_o
);

  localparam int NUM_LANES = XLEN / ELEM_WIDTH;
  localparam int DEPTH     = 2 ** ID_WIDTH;
  localparam logic [ID_WIDTH:0] C_FULL = {1'b1, {ID_WIDTH{1'b0}}};

  typedef enum logic [1:0] {S_FREE, S_BUSY, S_DONE} state_e;

  state_e              r_state [DEPTH];
  logic                r_cmt   [DEPTH];
  logic                r_kill  [DEPTH];
  logic                r_acc   [DEPTH];
  logic [4:0]          r_rd    [DEPTH];
  logic [XLEN-1:0]     r_sum   [DEPTH];
  logic [ID_WIDTH-1:0] r_fifo  [DEPTH];
  logic [ID_WIDTH-1:0] r_head;
  logic [ID_WIDTH-1:0] r_tail;
  logic [ID_WIDTH:0]   r_cnt;
  logic [XLEN-1:0]     r_accum;

  logic                r_pv   [LATENCY];
  logic [ID_WIDTH-1:0] r_pid  [LATENCY];
  logic [XLEN-1:0]     r_psum [LATENCY];

  logic [XLEN-1:0]     w_ea;
  logic [XLEN-1:0]     w_eb;
  logic [XLEN-1:0]     w_dot;
  logic [ID_WIDTH-1:0] w_head_id;
  logic                w_head_done;
  logic                w_kill_pop;
  logic                w_res_valid;
  logic                w_fire;
  logic                w_pop;
  logic                w_free_now;
  logic                w_issue;
  logic [XLEN-1:0]     w_res_data;

  // Lane products extended to XLEN and summed modulo 2**XLEN.
  always_comb begin
    w_ea  = '0;
    w_eb  = '0;
    w_dot = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      w_ea = {{(XLEN-ELEM_WIDTH){issue_signed_i &
              issue_rs1_i[l*ELEM_WIDTH+ELEM_WIDTH-1]}},
              issue_rs1_i[l*ELEM_WIDTH +: ELEM_WIDTH]};
      w_eb = {{(XLEN-ELEM_WIDTH){issue_signed_i &
              issue_rs2_i[l*ELEM_WIDTH+ELEM_WIDTH-1]}},
              issue_rs2_i[l*ELEM_WIDTH +: ELEM_WIDTH]};
      w_dot = w_dot + w_ea * w_eb;
    end
  end

  assign w_head_id   = r_fifo[r_head];
  assign w_head_done = (r_cnt != '0) && (r_state[w_head_id] == S_DONE);
  assign w_kill_pop  = w_head_done & r_kill[w_head_id];
  assign w_res_valid = w_head_done & r_cmt[w_head_id] & ~rst_i;
  assign w_fire      = w_res_valid & result_ready_i;
  assign w_pop       = w_kill_pop | w_fire;
  assign w_res_data  = r_sum[w_head_id] +
                       (r_acc[w_head_id] ? r_accum : '0);

  // A slot popped this cycle may be re-issued in the same cycle.
  assign w_free_now = (r_state[issue_id_i] == S_FREE) |
                      (w_pop & (w_head_id == issue_id_i));
  assign issue_ready_o = ~rst_i & w_free_now &
                         ((r_cnt != C_FULL) | w_pop);
  assign w_issue = issue_valid_i & issue_ready_o;

  assign result_valid_o = w_res_valid;
  assign result_we_o    = w_res_valid;
  assign result_id_o    = w_res_valid ? w_head_id : '0;
  assign result_rd_o    = w_res_valid ? r_rd[w_head_id] : '0;
  assign result_data_o  = w_res_valid ? w_res_data : '0;

  // Fixed-latency datapath pipeline; never stalls.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int s = 0; s < LATENCY; s++) begin
        r_pv[s]   <= 1'b0;
        r_pid[s]  <= '0;
        r_psum[s] <= '0;
      end
    end else begin
      r_pv[0]   <= w_issue;
      r_pid[0]  <= issue_id_i;
      r_psum[0] <= w_dot;
      for (int s = 1; s < LATENCY; s++) begin
        r_pv[s]   <= r_pv[s-1];
        r_pid[s]  <= r_pid[s-1];
        r_psum[s] <= r_psum[s-1];
      end
    end
  end

  // In-flight table, order FIFO and architectural accumulator.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_state[i] <= S_FREE;
        r_cmt[i]   <= 1'b0;
        r_kill[i]  <= 1'b0;
        r_acc[i]   <= 1'b0;
        r_rd[i]    <= '0;
        r_sum[i]   <= '0;
        r_fifo[i]  <= '0;
      end
      r_head  <= '0;
      r_tail  <= '0;
      r_cnt   <= '0;
      r_accum <= '0;
    end else begin
      if (r_pv[LATENCY-1]) begin
        r_state[r_pid[LATENCY-1]] <= S_DONE;
        r_sum[r_pid[LATENCY-1]]   <= r_psum[LATENCY-1];
      end
      if (commit_valid_i && r_state[commit_id_i] != S_FREE &&
          !r_cmt[commit_id_i] && !r_kill[commit_id_i]) begin
        if (commit_kill_i) r_kill[commit_id_i] <= 1'b1;
        else               r_cmt[commit_id_i]  <= 1'b1;
      end
      if (w_pop) begin
        r_state[w_head_id] <= S_FREE;
        r_head <= r_head + 1'b1;
      end
      if (w_fire && r_acc[w_head_id]) r_accum <= w_res_data;
      if (w_issue) begin
        r_state[issue_id_i] <= S_BUSY;
        r_cmt[issue_id_i]   <= 1'b0;
        r_kill[issue_id_i]  <= 1'b0;
        r_acc[issue_id_i]   <= issue_acc_i;
        r_rd[issue_id_i]    <= issue_rd_i;
        r_fifo[r_tail]      <= issue_id_i;
        r_tail <= r_tail + 1'b1;
      end
      r_cnt <= r_cnt + {{ID_WIDTH{1'b0}}, w_issue}
                     - {{ID_WIDTH{1'b0}}, w_pop};
    end
  end

endmodule

// File: tb/tb_cvxif_mac_pipe_coprocessor.sv
// tb_cvxif_mac_pipe_coprocessor: random + directed bench, 8-bit and 4-bit lanes.
// Reference model is a queue of in-flight ops with plain-arithmetic dot products.
module tb_cvxif_mac_pipe_coprocessor;

  localparam int LAT = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        iv = 1'b0;
  logic [2:0]  iid = '0;
  logic [4:0]  ird = '0;
  logic [31:0] rs1 = '0;
  logic [31:0] rs2 = '0;
  logic        isg = 1'b0;
  logic        iac = 1'b0;
  logic        cv = 1'b0;
  logic [2:0]  cid = '0;
  logic        ck = 1'b0;
  logic        rr = 1'b1;

  logic        o8_ready, o8_valid, o8_we;
  logic [2:0]  o8_id;
  logic [4:0]  o8_rd;
  logic [31:0] o8_data;
  logic        o4_ready, o4_valid, o4_we;
  logic [2:0]  o4_id;
  logic [4:0]  o4_rd;
  logic [31:0] o4_data;

  cvxif_mac_pipe_coprocessor #(
    .XLEN(32), .ELEM_WIDTH(8), .ID_WIDTH(3), .LATENCY(LAT)
  ) u_dut8 (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(iv), .issue_ready_o(o8_ready),
    .issue_id_i(iid), .issue_rd_i(ird),
    .issue_rs1_i(rs1), .issue_rs2_i(rs2),
    .issue_signed_i(isg), .issue_acc_i(iac),
    .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
    .result_valid_o(o8_valid), .result_ready_i(rr),
    .result_id_o(o8_id), .result_rd_o(o8_rd),
    .result_data_o(o8_data), .result_we_o(o8_we)
  );

  cvxif_mac_pipe_coprocessor #(
    .XLEN(32), .ELEM_WIDTH(4), .ID_WIDTH(3), .LATENCY(LAT)
  ) u_dut4 (
    .clk_i(clk), .rst_i(rst),
    .issue_valid_i(iv), .issue_ready_o(o4_ready),
    .issue_id_i(iid), .issue_rd_i(ird),
    .issue_rs1_i(rs1), .issue_rs2_i(rs2),
    .issue_signed_i(isg), .issue_acc_i(iac),
    .commit_valid_i(cv), .commit_id_i(cid), .commit_kill_i(ck),
    .result_valid_o(o4_valid), .result_ready_i(rr),
    .result_id_o(o4_id), .result_rd_o(o4_rd),
    .result_data_o(o4_data), .result_we_o(o4_we)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  typedef struct {
    int          id;
    logic [4:0]  rd;
    logic [31:0] s8;
    logic [31:0] s4;
    bit          acc;
    int          t;
    bit          cmt;
    bit          kil;
  } ent_t;

  ent_t        q[$];
  logic [31:0] acc8 = '0;
  logic [31:0] acc4 = '0;
  int          cyc = 0;

  function automatic logic [31:0] dot(input logic [31:0] a,
      input logic [31:0] b, input bit s, input int ew);
    longint sum = 0;
    longint m = (longint'(1) << ew) - 1;
    longint x, y;
    for (int i = 0; i < 32 / ew; i++) begin
      x = longint'(a >> (i * ew)) & m;
      y = longint'(b >> (i * ew)) & m;
      if (s && x > m / 2) x = x - (m + 1);
      if (s && y > m / 2) y = y - (m + 1);
      sum = sum + x * y;
    end
    return 32'(sum);
  endfunction

  function automatic bit head_done();
    return q.size() > 0 && cyc >= q[0].t + LAT;
  endfunction

  function automatic bit exp_valid();
    return !rst && head_done() && q[0].cmt && !q[0].kil;
  endfunction

  function automatic bit pop_now();
    return head_done() && (q[0].kil || (q[0].cmt && rr));
  endfunction

  function automatic bit exp_ready();
    bit inq = 0;
    if (rst) return 0;
    foreach (q[i]) if (q[i].id == int'(iid)) inq = 1;
    return (!inq || (pop_now() && q[0].id == int'(iid))) &&
           (q.size() < 8 || pop_now());
  endfunction

  // Reference model advances on every rising edge.
  always @(posedge clk) begin
    bit   p;
    bit   ir;
    ent_t e;
    if (rst) begin
      q.delete();
      acc8 = '0;
      acc4 = '0;
    end else begin
      p  = pop_now();
      ir = iv && exp_ready();
      if (cv)
        foreach (q[i])
          if (q[i].id == int'(cid) && !q[i].cmt && !q[i].kil) begin
            if (ck) q[i].kil = 1;
            else    q[i].cmt = 1;
          end
      if (p) begin
        if (!q[0].kil && q[0].acc) begin
          acc8 = q[0].s8 + acc8;
          acc4 = q[0].s4 + acc4;
        end
        void'(q.pop_front());
      end
      if (ir) begin
        e.id  = int'(iid);
        e.rd  = ird;
        e.s8  = dot(rs1, rs2, isg, 8);
        e.s4  = dot(rs1, rs2, isg, 4);
        e.acc = iac;
        e.t   = cyc + 1;
        e.cmt = 0;
        e.kil = 0;
        q.push_back(e);
      end
    end
    cyc++;
  end

  // Compare both DUTs against the model away from the clock edge.
  always @(negedge clk) begin
    bit ev;
    #1;
    ev = exp_valid();
    check("ready8", o8_ready, exp_ready());
    check("ready4", o4_ready, exp_ready());
    check("valid8", o8_valid, ev);
    check("valid4", o4_valid, ev);
    if (ev) begin
      check("id", o8_id, q[0].id);
      check("rd", o8_rd, q[0].rd);
      check("we", o8_we, 1);
      check("data8", o8_data, q[0].s8 + (q[0].acc ? acc8 : 32'd0));
      check("data4", o4_data, q[0].s4 + (q[0].acc ? acc4 : 32'd0));
    end
    if (rst) begin
      check("rst_data", o8_data, 0);
      check("rst_id", o8_id, 0);
      check("rst_rd", o8_rd, 0);
      check("rst_we", o8_we, 0);
    end
  end

  task automatic drive_idle();
    @(negedge clk);
    iv = 0;
    cv = 0;
  endtask

  task automatic drive_issue(input logic [2:0] id, input logic [31:0] a,
      input logic [31:0] b, input bit s, input bit ac);
    @(negedge clk);
    cv  = 0;
    iv  = 1;
    iid = id;
    ird = 5'(id) + 5'd10;
    rs1 = a;
    rs2 = b;
    isg = s;
    iac = ac;
  endtask

  task automatic drive_commit(input logic [2:0] id, input bit k);
    @(negedge clk);
    iv  = 0;
    cv  = 1;
    cid = id;
    ck  = k;
  endtask

  task automatic wait_valid();
    int n = 0;
    while (n < 30) begin
      drive_idle();
      #2;
      if (o8_valid) break;
      n++;
    end
    check("wait_valid", o8_valid, 1);
  endtask

  task automatic run_op(input logic [2:0] id, input logic [31:0] a,
      input logic [31:0] b, input bit s, input bit ac, input bit kl,
      input bit lane4, input logic [31:0] exp, input string tag);
    int t0;
    drive_issue(id, a, b, s, ac);
    t0 = cyc;
    drive_commit(id, kl);
    if (kl) begin
      repeat (LAT + 2) drive_idle();
    end else begin
      wait_valid();
      check({tag, "_data"}, lane4 ? o4_data : o8_data, exp);
      check({tag, "_lat"}, cyc - t0 - 1, LAT);
    end
    drive_idle();
  endtask

  initial begin
    rst = 1;
    rr  = 1;
    repeat (3) @(negedge clk);
    #2;
    check("rst_ready", o8_ready, 0);
    check("rst_valid", o8_valid, 0);
    @(negedge clk);
    rst = 0;

    run_op(3'd2, 32'h04030201, 32'h01010101, 0, 0, 0, 0,
           32'h0000000A, "basic");
    run_op(3'd4, 32'hFFFFFFFF, 32'h02020202, 1, 0, 0, 0,
           32'hFFFFFFF8, "signed");
    run_op(3'd4, 32'hFFFFFFFF, 32'h02020202, 0, 0, 0, 0,
           32'h000007F8, "unsigned");

    run_op(3'd3, 32'h04030201, 32'h01010101, 0, 1, 0, 0, 32'd10, "acc1");
    run_op(3'd3, 32'h04030201, 32'h01010101, 0, 1, 0, 0, 32'd20, "acc2");
    run_op(3'd3, 32'h04030201, 32'h01010101, 0, 1, 1, 0, 32'd0, "acck");
    run_op(3'd3, 32'h04030201, 32'h01010101, 0, 1, 0, 0, 32'd30, "acc3");

    rr = 0;
    drive_issue(3'd0, 32'h04030201, 32'h01010101, 0, 0);
    drive_issue(3'd1, 32'h01010101, 32'h01010101, 0, 0);
    drive_issue(3'd2, 32'h02020202, 32'h01010101, 0, 0);
    drive_commit(3'd1, 0);
    drive_commit(3'd2, 0);
    repeat (5) drive_idle();
    #2;
    check("blocked", o8_valid, 0);
    drive_commit(3'd0, 0);
    wait_valid();
    repeat (3) begin
      drive_idle();
      #2;
      check("hold_valid", o8_valid, 1);
      check("hold_id", o8_id, 0);
      check("hold_data", o8_data, 32'd10);
    end
    rr = 1;
    for (int k = 0; k < 3; k++) begin
      check("order_id", o8_id, k);
      drive_idle();
      #2;
    end

    for (int i = 0; i < 8; i++)
      drive_issue(3'(i), 32'h04030201, 32'h01010101, 0, 0);
    repeat (3) drive_idle();
    drive_idle();
    iid = 3'd3;
    #2;
    check("full_ready", o8_ready, 0);
    drive_commit(3'd0, 1);
    iid = 3'd0;
    #2;
    check("prefree_ready", o8_ready, 0);
    drive_issue(3'd0, 32'h01010101, 32'h01010101, 0, 0);
    #2;
    check("refree_ready", o8_ready, 1);
    for (int i = 1; i < 8; i++) drive_commit(3'(i), 1);
    drive_commit(3'd0, 1);
    repeat (LAT + 12) drive_idle();

    run_op(3'd5, 32'hFFFFFFFF, 32'h11111111, 1, 0, 0, 1,
           32'hFFFFFFF8, "e4signed");

    rr = 0;
    drive_issue(3'd1, 32'h04030201, 32'h01010101, 0, 1);
    drive_commit(3'd1, 0);
    wait_valid();
    @(negedge clk);
    rst = 1;
    iv  = 0;
    cv  = 0;
    #2;
    check("midrst_valid", o8_valid, 0);
    drive_idle();
    @(negedge clk);
    rst = 0;
    rr  = 1;
    run_op(3'd1, 32'h04030201, 32'h01010101, 0, 1, 0, 0,
           32'd10, "post_rst");

    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      rst = ($urandom % 400) == 0;
      iv  = $urandom % 2;
      iid = 3'($urandom);
      ird = 5'($urandom);
      rs1 = $urandom;
      rs2 = $urandom;
      isg = $urandom % 2;
      iac = ($urandom % 4) == 0;
      cv  = ($urandom % 3) == 0;
      cid = 3'($urandom);
      ck  = ($urandom % 5) == 0;
      rr  = ($urandom % 4) != 0;
    end
    @(negedge clk);
    rst = 0;
    iv  = 0;
    cv  = 0;
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
